// File: rtl/int_sqrt_bcd_engine.sv
// Multi-cycle integer square root with remainder, one root bit per cycle.
// Define SQRT_BCD_EN to add a sequential double-dabble stage and bcd port.
module int_sqrt_bcd_engine #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] sqrt,
  output logic [WIDTH/2:0]   rem
`ifdef SQRT_BCD_EN
  ,
  output logic [4*DIGITS-1:0] bcd
`endif
);

  localparam int R  = WIDTH / 2;
  localparam int CW = $clog2(R + 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("WIDTH must be even and >= 2");
  end
  if (10 ** DIGITS <= 2 ** R - 1) begin : g_bad_digits
    $error("DIGITS too small for root range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROOT,
    S_BCD,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] opnd;
  logic [R+2:0]     r;
  logic [R-1:0]     q;
  logic [CW-1:0]    cnt;

  logic [R+2:0]     rp;
  logic [R+2:0]     diff;
  logic [R+2:0]     r_n;
  logic [R-1:0]     q_n;
  logic             fits;
  logic             last;
  logic             accept;

  assign last   = (cnt == CW'(1));
  assign accept = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_ROOT;
`ifdef SQRT_BCD_EN
      S_ROOT: if (last) state_n = S_BCD;
      S_BCD:  if (last) state_n = S_DONE;
`else
      S_ROOT: if (last) state_n = S_DONE;
`endif
      S_DONE: state_n = start ? S_ROOT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ROOT) || (state == S_BCD);
    done = (state == S_DONE);
  end

  // Working remainder stays non-negative: a failed trial keeps r'.
  always_comb begin
    rp   = (r << 2) | (R+3)'(opnd[WIDTH-1 -: 2]);
    diff = rp - {1'b0, q, 2'b01};
    fits = ~diff[R+2];
    r_n  = fits ? diff : rp;
    q_n  = (q << 1) | R'(fits);
  end

`ifdef SQRT_BCD_EN
  logic [R-1:0]        bin;
  logic [4*DIGITS-1:0] dd;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] dd_n;

  always_comb begin
    adj = dd;
    for (int d = 0; d < DIGITS; d++) begin
      if (dd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = dd[4*d +: 4] + 4'd3;
    end
    dd_n = (adj << 1) | (4*DIGITS)'(bin[R-1]);
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      opnd <= '0;
      r    <= '0;
      q    <= '0;
      cnt  <= '0;
      sqrt <= '0;
      rem  <= '0;
`ifdef SQRT_BCD_EN
      bin  <= '0;
      dd   <= '0;
      bcd  <= '0;
`endif
    end else if (accept) begin
      opnd <= a;
      r    <= '0;
      q    <= '0;
      cnt  <= CW'(R);
    end else if (state == S_ROOT) begin
      opnd <= opnd << 2;
      r    <= r_n;
      q    <= q_n;
      cnt  <= cnt - CW'(1);
      if (last) begin
`ifdef SQRT_BCD_EN
        bin <= q_n;
        dd  <= '0;
        cnt <= CW'(R);
`else
        sqrt <= q_n;
        rem  <= r_n[R:0];
`endif
      end
    end
`ifdef SQRT_BCD_EN
    else if (state == S_BCD) begin
      bin <= bin << 1;
      dd  <= dd_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        sqrt <= q;
        rem  <= r[R:0];
        bcd  <= dd_n;
      end
    end
`endif
  end

endmodule

// File: tb/tb_int_sqrt_bcd_engine.sv
// Randomized and directed bench for int_sqrt_bcd_engine.
// Checks 8-bit and 16-bit instances against an arithmetic model.
module tb_int_sqrt_bcd_engine;

`ifdef SQRT_BCD_EN
  localparam int LAT8  = 9;
  localparam int LAT16 = 17;
`else
  localparam int LAT8  = 5;
  localparam int LAT16 = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        start8, start16;
  logic [7:0]  a8;
  logic [15:0] a16;
  logic        busy8, done8, busy16, done16;
  logic [3:0]  sqrt8;
  logic [4:0]  rem8;
  logic [7:0]  sqrt16;
  logic [8:0]  rem16;
  logic [7:0]  bcd8;
  logic [11:0] bcd16;

  int checks   = 0;
  int failures = 0;

  int_sqrt_bcd_engine #(.WIDTH(8), .DIGITS(2)) u8 (
    .clk(clk), .clr(clr), .start(start8), .a(a8),
    .busy(busy8), .done(done8), .sqrt(sqrt8), .rem(rem8)
`ifdef SQRT_BCD_EN
    , .bcd(bcd8)
`endif
  );

  int_sqrt_bcd_engine #(.WIDTH(16), .DIGITS(3)) u16 (
    .clk(clk), .clr(clr), .start(start16), .a(a16),
    .busy(busy16), .done(done16), .sqrt(sqrt16), .rem(rem16)
`ifdef SQRT_BCD_EN
    , .bcd(bcd16)
`endif
  );

`ifndef SQRT_BCD_EN
  assign bcd8  = '0;
  assign bcd16 = '0;
`endif

  function automatic int ref_sqrt(input int x);
    int s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  function automatic logic [11:0] ref_bcd(input int s);
    logic [11:0] d = '0;
    int v = s;
    for (int i = 0; i < 3; i++) begin
      d[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit w16, input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_c1", w16 ? busy16 : busy8, 1);
    end while (!(w16 ? done16 : done8) && n < 60);
    if (!(w16 ? done16 : done8)) n = -1;
  endtask

  task automatic res8(input string tag, input int av);
    int s = ref_sqrt(av);
    logic [11:0] b = ref_bcd(s);
    chk({tag, "_sqrt"}, sqrt8, s);
    chk({tag, "_rem"}, rem8, av - s * s);
`ifdef SQRT_BCD_EN
    chk({tag, "_bcd"}, bcd8, b[7:0]);
`endif
  endtask

  task automatic res16(input string tag, input int av);
    int s = ref_sqrt(av);
    logic [11:0] b = ref_bcd(s);
    chk({tag, "_sqrt"}, sqrt16, s);
    chk({tag, "_rem"}, rem16, av - s * s);
`ifdef SQRT_BCD_EN
    chk({tag, "_bcd"}, bcd16, b);
`endif
  endtask

  task automatic run8(input logic [7:0] av, input string tag);
    int n;
    start8 = 1'b1;
    a8 = av;
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'($urandom);
    wait_done(1'b0, 0, n);
    chk({tag, "_lat"}, n, LAT8);
    res8(tag, int'(av));
    @(negedge clk);
    chk({tag, "_pulse"}, done8, 0);
  endtask

  task automatic run16(input logic [15:0] av, input string tag);
    int n;
    start16 = 1'b1;
    a16 = av;
    @(posedge clk);
    #1 start16 = 1'b0;
    a16 = 16'($urandom);
    wait_done(1'b1, 0, n);
    chk({tag, "_lat"}, n, LAT16);
    res16(tag, int'(av));
    @(negedge clk);
    chk({tag, "_pulse"}, done16, 0);
  endtask

  initial begin
    int n;
    int dn;
    clr = 1'b1;
    start8 = 1'b0;
    start16 = 1'b0;
    a8 = '0;
    a16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {busy8, busy16}, 0);
    chk("rst_done", {done8, done16}, 0);
    chk("rst_out8", {sqrt8, rem8, bcd8}, 0);
    chk("rst_out16", {sqrt16, rem16, bcd16}, 0);
    clr = 1'b0;
    @(negedge clk);

    run8(8'd255, "max8");
    run8(8'd0, "zero8");
    run8(8'd99, "a99");

    // back-to-back: start held through DONE
    start8 = 1'b1;
    a8 = 8'd144;
    @(posedge clk);
    #1 a8 = 8'd0;
    wait_done(1'b0, 0, n);
    chk("b2b1_lat", n, LAT8);
    res8("b2b1", 144);
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'hA5;
    wait_done(1'b0, 0, n);
    chk("b2b2_gap", n, LAT8);
    res8("b2b2", 0);
    @(negedge clk);

    // start re-pulsed while busy is ignored
    start8 = 1'b1;
    a8 = 8'd50;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'd200;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done(1'b0, 2, n);
    chk("ign_lat", n, LAT8);
    res8("ign", 50);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("ign_single", dn, 0);

    // clr aborts an operation in progress
    start8 = 1'b1;
    a8 = 8'd255;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy8, 0);
    chk("clr_out", {done8, sqrt8, rem8, bcd8}, 0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("clr_nodone", dn, 0);

    for (int i = 0; i < 12; i++) run8(8'($urandom), "rnd8");

    run16(16'd65535, "max16");
    run16(16'd10000, "a10000");
    run16(16'd0, "zero16");
    for (int i = 0; i < 8; i++) run16(16'($urandom), "rnd16");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
